uart_rx_frame: RTL and testbench

//  Standalone UART receiver: the far end of the UART transmit path. Recovers
//  8N1/8E1 frames from a serial line using 16x oversampling at a baud_sel-chosen

---
 rtl/uart_rx_frame.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receiver, 8N1/8E1, 16x oversampling, selectable baud divider
module uart_rx_frame #(
    parameter int PARITY_EN = 1,
    parameter int DIV_B0    = 651,
    parameter int DIV_B1    = 326,
    parameter int DIV_B2    = 163,
    parameter int DIV_B3    = 54
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] baud_sel,
    input  logic       RX_in,
    output logic [7:0] RX_DATA_OUT,
    output logic       RXvalid,
    output logic       RXbusy,
    output logic       parity_error,
    output logic       stop_bit_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [9:0] DIV0_M1 = 10'(DIV_B0 - 1);
    localparam logic [9:0] DIV1_M1 = 10'(DIV_B1 - 1);
    localparam logic [9:0] DIV2_M1 = 10'(DIV_B2 - 1);
    localparam logic [9:0] DIV3_M1 = 10'(DIV_B3 - 1);

    state_t      state_q, state_d;
    logic        sync1_q, rx_s_q, rx_prev_q;
    logic [1:0]  baud_q;
    logic [9:0]  tick_cnt_q, tick_cnt_d;
    logic [3:0]  samp_cnt_q, samp_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        perr_q, perr_d;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        perr_out_q, perr_out_d;
    logic        serr_out_q, serr_out_d;

    logic [9:0]  div_m1;
    logic        tick;
    logic        baud_chg;
    logic        sample_pt;
    logic [3:0]  sample_cnt_target;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            baud_q     <= 2'd0;
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            serr_out_q <= 1'b0;
        end else begin
            sync1_q    <= RX_in;
            rx_s_q     <= sync1_q;
            rx_prev_q  <= rx_s_q;
            baud_q     <= baud_sel;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            serr_out_q <= serr_out_d;
        end
    end

    always_comb begin
        div_m1 = DIV0_M1;
        case (baud_q)
            2'd0:    div_m1 = DIV0_M1;
            2'd1:    div_m1 = DIV1_M1;
            2'd2:    div_m1 = DIV2_M1;
            default: div_m1 = DIV3_M1;
        endcase
    end

    // START samples half a bit in; later bits sample a full 16 ticks after the previous sample
    assign sample_cnt_target = (state_q == S_START) ? 4'd7 : 4'd15;
    assign tick              = (tick_cnt_q >= div_m1);
    assign baud_chg          = (baud_sel != baud_q);
    assign sample_pt         = tick && (samp_cnt_q == sample_cnt_target);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? 10'd0 : tick_cnt_q + 10'd1;
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        serr_out_d = serr_out_q;

        if (tick) begin
            samp_cnt_d = sample_pt ? 4'd0 : samp_cnt_q + 4'd1;
        end

        if (baud_chg) begin
            // A rate change mid-frame makes the remaining samples meaningless: abort silently
            tick_cnt_d = '0;
            samp_cnt_d = '0;
            state_d    = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    samp_cnt_d = '0;
                    if (rx_prev_q && !rx_s_q) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (sample_pt) begin
                        if (!rx_s_q) begin
                            state_d   = S_DATA;
                            bit_idx_d = '0;
                            perr_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (sample_pt) begin
                        shift_d   = {rx_s_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (sample_pt) begin
                        perr_d  = (^shift_q) ^ rx_s_q;
                        state_d = S_STOP;
                    end
                end
                S_STOP: begin
                    if (sample_pt) begin
                        data_out_d = shift_q;
                        perr_out_d = (PARITY_EN != 0) ? perr_q : 1'b0;
                        serr_out_d = ~rx_s_q;
                        valid_d    = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign RX_DATA_OUT    = data_out_q;
    assign RXvalid        = valid_q;
    assign RXbusy         = (state_q != S_IDLE);
    assign parity_error   = perr_out_q;
    assign stop_bit_error = serr_out_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame (DIV_B1=4, 64 clocks per bit)
module tb_uart_rx_frame;

    localparam int BIT_CLKS = 64;

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
        int         gap;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] baud_sel = 2'd1;
    logic       RX_in = 1'b1;
    logic [7:0] RX_DATA_OUT;
    logic       RXvalid;
    logic       RXbusy;
    logic       parity_error;
    logic       stop_bit_error;

    int   tests = 0;
    int   fails = 0;
    int   valid_cnt = 0;
    logic busy_seen = 1'b0;
    logic prev_valid = 1'b0;
    exp_t sb[$];
    vec_t vecs[6];

    uart_rx_frame #(
        .PARITY_EN(1),
        .DIV_B1   (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .baud_sel      (baud_sel),
        .RX_in         (RX_in),
        .RX_DATA_OUT   (RX_DATA_OUT),
        .RXvalid       (RXvalid),
        .RXbusy        (RXbusy),
        .parity_error  (parity_error),
        .stop_bit_error(stop_bit_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (RXbusy) busy_seen = 1'b1;
            if (RXvalid) begin
                exp_t e;
                valid_cnt++;
                check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got data %0h with no frame expected", RX_DATA_OUT);
                end else begin
                    e = sb.pop_front();
                    check("rx_data", {24'd0, RX_DATA_OUT}, {24'd0, e.data});
                    check("parity_error", {31'd0, parity_error}, {31'd0, e.perr});
                    check("stop_bit_error", {31'd0, stop_bit_error}, {31'd0, e.serr});
                end
            end
        end
        prev_valid = RXvalid;
    end

    task automatic drive_bit(input logic v);
        RX_in = v;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stp,
                              input int gap, input logic expect_it);
        exp_t e;
        logic p;
        p = (^d) ^ bad_par;
        if (expect_it) begin
            e.data = d;
            e.perr = bad_par;
            e.serr = ~stp;
            sb.push_back(e);
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(stp);
        for (int i = 0; i < gap; i++) drive_bit(1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, {24'd0, RX_DATA_OUT}, 32'd0);
        check({tag, "_valid"}, {31'd0, RXvalid}, 32'd0);
        check({tag, "_busy"}, {31'd0, RXbusy}, 32'd0);
        check({tag, "_perr"}, {31'd0, parity_error}, 32'd0);
        check({tag, "_serr"}, {31'd0, stop_bit_error}, 32'd0);
    endtask

    initial begin
        int vc;
        int waited;
        vecs[0] = '{data: 8'hB3, bad_par: 1'b0, stop: 1'b1, gap: 2};
        vecs[1] = '{data: 8'hB3, bad_par: 1'b1, stop: 1'b1, gap: 2};
        vecs[2] = '{data: 8'hA5, bad_par: 1'b0, stop: 1'b1, gap: 1};
        vecs[3] = '{data: 8'h00, bad_par: 1'b0, stop: 1'b1, gap: 0};
        vecs[4] = '{data: 8'hFF, bad_par: 1'b0, stop: 1'b1, gap: 2};
        vecs[5] = '{data: 8'h3C, bad_par: 1'b1, stop: 1'b0, gap: 2};

        repeat (5) @(negedge clock);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        repeat (BIT_CLKS) @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop, vecs[i].gap, 1'b1);
        end
        check("table_frames", valid_cnt, 32'd6);

        // Break frame followed by a line stuck low
        vc = valid_cnt;
        send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b1);
        RX_in = 1'b0;
        repeat (10 * BIT_CLKS) @(negedge clock);
        check("break_single_valid", valid_cnt, vc + 1);
        check("stuck_low_idle", {31'd0, RXbusy}, 32'd0);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // Short glitch on idle line
        vc = valid_cnt;
        busy_seen = 1'b0;
        RX_in = 1'b0;
        repeat (12) @(negedge clock);
        RX_in = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_busy_done", {31'd0, RXbusy}, 32'd0);
        check("glitch_no_valid", valid_cnt, vc);

        // Reset asserted after data bit 3 of 0xC4
        vc = valid_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC4 >> i));
        repeat (BIT_CLKS / 2) @(negedge clock);
        reset_n = 1'b0;
        RX_in = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clock);
        check("midreset_no_valid", valid_cnt, vc);
        send_frame(8'hC4, 1'b0, 1'b1, 2, 1'b1);
        check("after_reset_frame", valid_cnt, vc + 1);

        // baud_sel change mid-frame aborts the frame
        vc = valid_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'(8'hC4 >> i));
        baud_sel = 2'd2;
        repeat (4) @(negedge clock);
        check("baudchg_busy", {31'd0, RXbusy}, 32'd0);
        RX_in = 1'b1;
        baud_sel = 2'd1;
        repeat (12 * BIT_CLKS) @(negedge clock);
        check("baudchg_no_valid", valid_cnt, vc);
        send_frame(8'hC4, 1'b0, 1'b1, 2, 1'b1);
        check("after_baudchg_frame", valid_cnt, vc + 1);

        waited = 0;
        while (sb.size() != 0 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
